// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: stream handshakes and datapath control lines between the
// multiplier controller (slave side) and its surroundings (master side).
interface mul_ctrl_if;
    logic istream_val, istream_rdy, ostream_val, ostream_rdy, b_lsb;
    logic a_mux_sel, b_mux_sel, r_mux_sel, add_mux_sel, r_en, busy;
    modport slave (
        input  istream_val, ostream_rdy, b_lsb,
        output istream_rdy, ostream_val, a_mux_sel, b_mux_sel, r_mux_sel, add_mux_sel, r_en, busy
    );
    modport master (
        output istream_val, ostream_rdy, b_lsb,
        input  istream_rdy, ostream_val, a_mux_sel, b_mux_sel, r_mux_sel, add_mux_sel, r_en, busy
    );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences the shift-and-add datapath for NBITS iterations per
// operand pair, then holds the product until the consumer takes it.
module mul_ctrl #(
    parameter int NBITS = 32
) (
    input  logic       clk,
    input  logic       rst,
    mul_ctrl_if.slave  io
);
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE values are the defaults; the 2'b11 encoding falls back to them
    always_comb begin
        state_d        = IDLE;
        cnt_d          = '0;
        io.istream_rdy = 1'b1;
        io.ostream_val = 1'b0;
        io.busy        = 1'b0;
        io.a_mux_sel   = 1'b0;
        io.b_mux_sel   = 1'b0;
        io.r_mux_sel   = 1'b0;
        io.add_mux_sel = 1'b0;
        io.r_en        = 1'b1;
        case (state_q)
            IDLE: state_d = io.istream_val ? CALC : IDLE;
            CALC: begin
                io.istream_rdy = 1'b0;
                io.busy        = 1'b1;
                io.a_mux_sel   = 1'b1;
                io.b_mux_sel   = 1'b1;
                io.r_mux_sel   = 1'b1;
                io.add_mux_sel = io.b_lsb;
                state_d        = (cnt_q == LAST) ? DONE : CALC;
                cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            DONE: begin
                io.istream_rdy = 1'b0;
                io.ostream_val = 1'b1;
                io.busy        = 1'b1;
                io.a_mux_sel   = 1'b1;
                io.b_mux_sel   = 1'b1;
                io.r_mux_sel   = 1'b1;
                io.r_en        = 1'b0;
                state_d        = io.ostream_rdy ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Control unit for the iterative shift-and-add multiplier datapath `data_path`.
- Accepts one operand pair per val/rdy handshake on the input stream. Sequences the datapath mux selects and result enable for exactly NBITS iterations, then presents the result with a val/rdy handshake on the output stream.
- Instantiated beside `data_path`; together they form the top-level iterative multiplier.

Parameters:
- NBITS, 32, iteration count (operand width). Legal range 2..64.
- CNT_W, $clog2(NBITS), iteration counter width. Derived; not overridden.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- istream_val  input  1  operand pair valid on datapath istream_msg
- istream_rdy  output  1  controller can accept an operand pair
- ostream_val  output  1  datapath ostream_msg holds the final product
- ostream_rdy  input  1  consumer accepts the product
- b_lsb  input  1  bit 0 of the datapath B register
- b_mux_sel  output  1  0 = load B from the stream, 1 = B shifted right
- a_mux_sel  output  1  0 = load A from the stream, 1 = A shifted left
- r_mux_sel  output  1  0 = clear result, 1 = take the add mux output
- add_mux_sel  output  1  1 = partial sum (A+R), 0 = hold R
- r_en  output  1  result register write enable
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset:
  - rst low forces state=IDLE and cnt=0 immediately, independent of clk.
  - Outputs take their IDLE values; an operation in flight is abandoned and no ostream_val is issued for it.
- States are IDLE, CALC and DONE. Any unreachable encoding recovers to IDLE on the next clk.
- IDLE outputs: istream_rdy=1, ostream_val=0, busy=0, a_mux_sel=0, b_mux_sel=0, r_mux_sel=0, add_mux_sel=0, r_en=1.
  - The datapath therefore continuously loads operands and clears R.
- IDLE -> CALC on the clk edge where istream_val=1. That edge captures A, B and R=0. cnt<=0.
- CALC outputs: istream_rdy=0, ostream_val=0, busy=1, a_mux_sel=1, b_mux_sel=1, r_mux_sel=1, r_en=1.
  - add_mux_sel = b_lsb. This is the only combinational (Mealy) path; it carries no register delay.
- In CALC, cnt increments each clk.
  - CALC -> DONE on the edge where cnt==NBITS-1, giving exactly NBITS CALC cycles. cnt<=0 on exit.
- DONE outputs: ostream_val=1, istream_rdy=0, busy=1, a_mux_sel=1, b_mux_sel=1, r_mux_sel=1, add_mux_sel=0, r_en=0.
  - R holds while the A and B registers keep shifting; their values are don't-care.
- DONE -> IDLE on the edge where ostream_rdy=1.
  - ostream_val stays high and R stays stable for as long as ostream_rdy=0 (backpressure of unbounded length).
- Latency: handshake at edge t puts the FSM in CALC for cycles t+1..t+NBITS. ostream_val rises after edge t+NBITS, so it is visible in cycle t+NBITS+1.
- Minimum initiation interval is NBITS+2 cycles. There is no overlap: istream_rdy is 0 in both CALC and DONE.
- istream_val high in CALC or DONE is ignored; nothing is captured and no state changes.
- ostream_rdy is ignored outside DONE.
- Every output except add_mux_sel is a decode of the registered state only.

Test Plan:
- Reset release:
  - Stimulus: rst low 3 cycles, then high; val inputs 0.
  - Required: istream_rdy=1, ostream_val=0, busy=0, r_en=1, r_mux_sel=0 on every cycle.
- Single op, NBITS=32:
  - Stimulus: istream_val pulse at edge t; ostream_rdy=1.
  - Required: exactly 32 CALC cycles; ostream_val high for the single cycle t+33; back in IDLE at t+34.
- add_mux_sel tracking:
  - Stimulus: drive b_lsb=1,0,1,1,0,... during CALC.
  - Required: add_mux_sel equals b_lsb in the same cycle; add_mux_sel=0 in IDLE and DONE.
- Integrated with `data_path`, unsigned products:
  - 6*7 -> ostream_msg=42.
  - 0xFFFF*0x3 -> 0x2FFFD.
  - 0*0x1234 -> 0.
- Backpressure:
  - Stimulus: ostream_rdy=0 for 10 cycles in DONE, istream_val=1 throughout.
  - Required: ostream_val and R stable; istream_rdy=0; nothing accepted until the DONE handshake completes.
- Reset mid-CALC:
  - Stimulus: assert rst at cnt=15.
  - Required: IDLE immediately (async); busy=0; no ostream_val; the next op (5*5) returns 25.
